// File: rtl/vmem_seq.sv
// Strided vector load/store sequencer that shares a single-port word memory
// with the scalar load/store path. It issues one 32-bit element access per
// cycle, packs load results into rdata, and always yields the port to the
// scalar path when s_req is high.
module vmem_seq #(
  parameter int VLMAX = 8,
  parameter int ELEN  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_store,
  input  logic [31:0]                 cmd_base,
  input  logic [31:0]                 cmd_stride,
  input  logic [$clog2(VLMAX):0]      cmd_vl,
  input  logic [VLMAX*ELEN-1:0]       cmd_wdata,
  output logic [VLMAX*ELEN-1:0]       rdata,
  output logic                        busy,
  output logic                        done,
  input  logic                        s_req,
  input  logic [3:0]                  s_we,
  input  logic [31:0]                 s_addr,
  input  logic [31:0]                 s_wdata,
  output logic [31:0]                 s_rdata,
  output logic [31:0]                 mem_addr,
  output logic [3:0]                  mem_we,
  output logic [31:0]                 mem_datain,
  input  logic [31:0]                 mem_dataout
);

  localparam int CW = $clog2(VLMAX) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_store;
  logic [CW-1:0]           r_vl;
  logic [CW-1:0]           r_idx;
  logic [31:0]             r_cur_addr;
  logic signed [31:0]      r_stride;
  logic [VLMAX*ELEN-1:0]   r_wdata;
  logic [VLMAX*ELEN-1:0]   r_rdata;
  logic [CW-1:0]           w_eff_vl;
  logic                    w_accept;
  logic                    w_issue;
  logic                    w_last;
  logic [ELEN-1:0]         w_wdata_el;

  // Command acceptance, clamped element count and per-element issue qualifiers.
  // Issue is suppressed while rst is high so an aborted store writes nothing
  // further on the reset edge.
  always_comb begin
    w_eff_vl = (cmd_vl > CW'(VLMAX)) ? CW'(VLMAX) : cmd_vl;
    w_accept = (r_state == S_IDLE) && cmd_valid;
    w_issue  = (r_state == S_RUN) && !s_req && !rst;
    w_last   = (r_idx == (r_vl - 1'b1));
  end

  // Select the store element for the current index.
  always_comb begin
    w_wdata_el = '0;
    for (int i = 0; i < VLMAX; i++) begin
      if (r_idx == CW'(i)) w_wdata_el = r_wdata[i*ELEN +: ELEN];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: zero-length commands go straight to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_eff_vl == '0) ? S_DONE : S_RUN;
      S_RUN:  if (w_issue && w_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state: index, running address, store flag, vl and the load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_store    <= 1'b0;
      r_vl       <= '0;
      r_idx      <= '0;
      r_cur_addr <= '0;
      r_rdata    <= '0;
    end else if (w_accept) begin
      r_store    <= cmd_store;
      r_vl       <= w_eff_vl;
      r_idx      <= '0;
      r_cur_addr <= cmd_base;
      if (!cmd_store) r_rdata <= '0;
    end else if (w_issue) begin
      r_idx      <= r_idx + 1'b1;
      r_cur_addr <= r_cur_addr + r_stride;
      if (!r_store) begin
        for (int i = 0; i < VLMAX; i++) begin
          if (r_idx == CW'(i)) r_rdata[i*ELEN +: ELEN] <= mem_dataout;
        end
      end
    end
  end

  // Command data captured at accept; not reset since it is only read in RUN.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_stride <= cmd_stride;
      r_wdata  <= cmd_wdata;
    end
  end

  // Memory port mux: scalar path first, then vector issue, otherwise idle.
  always_comb begin
    mem_addr   = '0;
    mem_we     = '0;
    mem_datain = '0;
    if (s_req) begin
      mem_addr   = s_addr;
      mem_we     = s_we;
      mem_datain = s_wdata;
    end else if (w_issue) begin
      mem_addr   = r_cur_addr;
      mem_we     = r_store ? 4'b1111 : 4'b0000;
      mem_datain = r_store ? w_wdata_el : '0;
    end
  end

  // Status outputs.
  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    busy      = (r_state == S_RUN) || (r_state == S_DONE);
    done      = (r_state == S_DONE);
    rdata     = r_rdata;
    s_rdata   = mem_dataout;
  end

endmodule

// File: doc/vmem_seq.md
Name: vmem_seq

Overview:
Vector load/store sequencer in front of the single-port word data memory (combinational read, synchronous write, byte-enable `we[3:0]`). It accepts one strided vector memory command at a time and issues one 32-bit element access per cycle. Loaded elements are packed into a result register, and store elements are unpacked from a packed source. It also arbitrates the memory port with the scalar load/store path; the scalar path has fixed priority.

Parameters:
- VLMAX, 8, maximum elements per command; the element index and vl counters are $clog2(VLMAX)+1 bits wide.
- ELEN, 32, element width in bits; equals the memory word width and is fixed at 32.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  vector command present.
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
- cmd_store  in  1  1 = vector store, 0 = vector load.
- cmd_base  in  32  byte address of element 0.
- cmd_stride  in  32  signed byte stride between consecutive elements.
- cmd_vl  in  $clog2(VLMAX)+1  element count.
- cmd_wdata  in  VLMAX*ELEN  store data; element i is at [32i+31:32i].
- rdata  out  VLMAX*ELEN  load result register, same packing as cmd_wdata.
- busy  out  1  command in progress (RUN or DONE).
- done  out  1  one-cycle completion pulse.
- s_req  in  1  scalar access request this cycle.
- s_we  in  4  scalar byte enables.
- s_addr  in  32  scalar address.
- s_wdata  in  32  scalar write data.
- s_rdata  out  32  scalar read data, equal to mem_dataout.
- mem_addr  out  32  memory address.
- mem_we  out  4  memory byte enables.
- mem_datain  out  32  memory write data.
- mem_dataout  in  32  memory combinational read data.

Behaviour:
- **Reset.** On reset: state IDLE, cmd_ready=1, busy=0, done=0, rdata=0, internal idx=0, internal cur_addr=0. Reset has priority over every other event.
- **States.** IDLE, RUN, DONE.
- **IDLE.**
  - cmd_ready=1.
  - On cmd_valid at a clock edge, latch store flag, base, stride, wdata and eff_vl = min(cmd_vl, VLMAX). Set idx=0 and cur_addr=cmd_base.
  - For a load, clear rdata to 0 at the accept edge, so tail elements read as 0.
  - If eff_vl==0, go to DONE; otherwise go to RUN.
- **RUN, with s_req=1.**
  - The scalar path owns the port: mem_addr=s_addr, mem_we=s_we, mem_datain=s_wdata.
  - Vector state holds; no element is issued.
- **RUN, with s_req=0.** Issue element idx:
  - mem_addr = cur_addr.
  - Store: mem_we=4'b1111, mem_datain = wdata element idx.
  - Load: mem_we=0, and rdata element idx <= mem_dataout at the edge.
  - At the edge: idx <= idx+1 and cur_addr <= cur_addr + stride (modulo 2^32; wraps silently).
  - When idx==eff_vl-1 is issued, go to DONE.
- **DONE.**
  - done=1 for exactly one cycle, then go to IDLE.
  - The scalar path still passes through.
- **Memory port outside vector issue.**
  - In IDLE and DONE: scalar pass-through when s_req=1; otherwise mem_addr=0, mem_we=0, mem_datain=0.
  - s_rdata = mem_dataout at all times.
- **Latency.** With no scalar interference, done is high N+1 cycles after the accept cycle for eff_vl=N≥1, and 1 cycle after accept for eff_vl=0. Each scalar-stall cycle adds exactly one cycle.
- **Address handling.** cur_addr[1:0] is passed through unmodified; word alignment is the memory's responsibility. No misalignment fault is raised.
- **Starvation.** Continuous s_req stalls a vector command indefinitely; this is accepted by design.
- **Commands while busy.** cmd_valid while busy is ignored (cmd_ready=0) and is not queued.
- **rdata retention.** rdata is held after a load until the next load command is accepted. Stores never modify rdata.
- **Reset mid-operation.** Aborts at the reset edge. Elements already written stay written, no further memory writes occur, and done is not pulsed.

Test Plan:
1. **Unit-stride load.** Memory words 4..7 = 3, 5, fffffff9, fffffffb. Command: load, base 0x10, stride 4, vl 4 → done 5 cycles after accept; rdata[127:0] = fffffffb_fffffff9_00000005_00000003; rdata[255:128] = 0.
2. **Strided store.** Store, base 0x40, stride 8, vl 3, wdata elements A, B, C → mem_we=1111 in 3 consecutive cycles at 0x40, 0x48, 0x50; memory readback returns A, B, C.
3. **Scalar interference.** s_req held for 2 cycles during element 1 of a vl-4 load (s_addr=0x20) → vector stalls; s_rdata = memory word 8 (00000008); done 7 cycles after accept; rdata unchanged versus an uninterrupted run.
4. **vl boundaries.**
   - vl=0 → done the next cycle, no mem_we activity, rdata cleared for a load.
   - vl=12 → clamped to 8, exactly 8 accesses issued.
5. **Negative stride.** Load, base 0x5C, stride -4 (ffff_fffc), vl 4 → addresses 0x5C, 0x58, 0x54, 0x50; rdata elements = words 0x17, 0x16, 0x15, 0x14.
6. **Reset mid-store.** vl-4 store, with rst asserted after 2 elements are written → only 2 memory writes; IDLE with cmd_ready=1 and done=0 on the following cycle.
